// File: rtl/count_sequencer_if.sv
// rtl/count_sequencer_if.sv - control/status bundle between run control logic and count_sequencer
interface count_sequencer_if #(
  parameter int WIDTH = 6
) ();
  logic             start_i;
  logic             stop_i;
  logic             pause_i;
  logic             mode_i;
  logic [WIDTH-1:0] limit_i;
  logic [WIDTH-1:0] count_o;
  logic             tick_o;
  logic             done_o;
  logic             busy_o;
  logic [1:0]       state_o;

  modport master (
    output start_i, stop_i, pause_i, mode_i, limit_i,
    input  count_o, tick_o, done_o, busy_o, state_o
  );

  modport slave (
    input  start_i, stop_i, pause_i, mode_i, limit_i,
    output count_o, tick_o, done_o, busy_o, state_o
  );
endinterface

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - prescaled run/pause/stop sequencer for the shared event counter
module count_sequencer #(
  parameter int DIV   = 10,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  count_sequencer_if.slave bus
);
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [PW-1:0]    presc_q, presc_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] limit_q, limit_n;
  logic             mode_q, mode_n;
  logic             tick_q, tick_n;
  logic             done_q, done_n;
  logic             busy_q, busy_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      presc_q <= presc_n;
      count_q <= count_n;
      limit_q <= limit_n;
      mode_q  <= mode_n;
      tick_q  <= tick_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
    end
  end

  // Priority: stop, then start (only from IDLE/DONE), then pause, then prescaler advance.
  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    count_n = count_q;
    limit_n = limit_q;
    mode_n  = mode_q;
    tick_n  = 1'b0;
    done_n  = 1'b0;

    if (bus.stop_i) begin
      state_n = IDLE;
      presc_n = '0;
      count_n = '0;
    end else if (bus.start_i && (state_q == IDLE || state_q == DONE)) begin
      state_n = RUN;
      presc_n = '0;
      count_n = '0;
      limit_n = bus.limit_i;
      mode_n  = bus.mode_i;
    end else if (state_q == RUN || state_q == PAUSE) begin
      if (bus.pause_i) begin
        state_n = PAUSE;
      end else begin
        state_n = RUN;
        if (presc_q == DIV_M1) begin
          presc_n = '0;
          tick_n  = 1'b1;
          if (count_q < limit_q) begin
            count_n = count_q + WIDTH'(1);
          end else begin
            done_n = 1'b1;
            if (mode_q) count_n = '0;
            else        state_n = DONE;
          end
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
    end

    busy_n = (state_n == RUN) || (state_n == PAUSE);
  end

  assign bus.count_o = count_q;
  assign bus.tick_o  = tick_q;
  assign bus.done_o  = done_q;
  assign bus.busy_o  = busy_q;
  assign bus.state_o = state_q;
endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer
module tb_count_sequencer;
  localparam int DIV   = 10;
  localparam int WIDTH = 6;

  typedef struct {
    int               at;
    logic [WIDTH-1:0] cnt;
    logic             done;
    logic [1:0]       st;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   edge_n = 0;
  int   pause_from = 0;
  int   pause_to = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ev_t  sb[$];

  count_sequencer_if #(.WIDTH(WIDTH)) bus ();

  count_sequencer #(.DIV(DIV), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected tick events for a run started at edge k; events at or after the pause window shift by its length.
  task automatic push_run(input int k, input int lim, input bit mode, input int nper,
                          input int p_at, input int p_len);
    int total;
    ev_t e;
    total = (mode ? nper : 1) * (lim + 1);
    for (int n = 1; n <= total; n++) begin
      e.at = k + n * DIV;
      if (e.at >= p_at) e.at += p_len;
      if (mode) begin
        e.cnt  = WIDTH'(n % (lim + 1));
        e.done = ((n % (lim + 1)) == 0);
        e.st   = 2'd1;
      end else begin
        e.cnt  = (n <= lim) ? WIDTH'(n) : WIDTH'(lim);
        e.done = (n == lim + 1);
        e.st   = (n == lim + 1) ? 2'd3 : 2'd1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic run_watch(input int n);
    for (int i = 0; i < n; i++) begin
      bit  paused;
      ev_t e;
      paused = (edge_n + 1 >= pause_from) && (edge_n + 1 < pause_to);
      bus.pause_i = paused;
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      if (paused) begin
        n_chk++;
        if (bus.state_o !== 2'd2 || bus.tick_o !== 1'b0) begin
          n_fail++;
          $display("FAIL paused edge %0d: state=%0d tick=%b, required state=2 tick=0",
                   edge_n, bus.state_o, bus.tick_o);
        end
      end
      if (bus.tick_o === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tick edge %0d: count=%0d done=%b, required no tick",
                   edge_n, bus.count_o, bus.done_o);
        end else begin
          e = sb.pop_front();
          if (edge_n !== e.at || bus.count_o !== e.cnt || bus.done_o !== e.done ||
              bus.state_o !== e.st || bus.busy_o !== (e.st != 2'd3)) begin
            n_fail++;
            $display("FAIL tick_event edge %0d count=%0d done=%b state=%0d busy=%b, required edge %0d count=%0d done=%b state=%0d",
                     edge_n, bus.count_o, bus.done_o, bus.state_o, bus.busy_o,
                     e.at, e.cnt, e.done, e.st);
          end
        end
      end else if (bus.done_o !== 1'b0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_without_tick edge %0d: done=%b, required 0", edge_n, bus.done_o);
      end
    end
    bus.pause_i = 1'b0;
  endtask

  task automatic check_drained(input string name);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s drained: %0d events outstanding, required 0 (next at edge %0d)",
               name, sb.size(), sb[0].at);
      sb.delete();
    end
  endtask

  task automatic check_status(input string name, input logic [1:0] st,
                              input logic [WIDTH-1:0] cnt, input logic busy);
    n_chk++;
    if (bus.state_o !== st || bus.count_o !== cnt || bus.busy_o !== busy) begin
      n_fail++;
      $display("FAIL %s: state=%0d count=%0d busy=%b, required state=%0d count=%0d busy=%b",
               name, bus.state_o, bus.count_o, bus.busy_o, st, cnt, busy);
    end
  endtask

  task automatic do_start(input int lim, input bit mode, input int nper,
                          input int p_after, input int p_len, output int k);
    bus.limit_i = WIDTH'(lim);
    bus.mode_i  = mode;
    bus.start_i = 1'b1;
    run_watch(1);
    bus.start_i = 1'b0;
    k = edge_n;
    check_status("start_edge", 2'd1, '0, 1'b1);
    if (p_len > 0) begin
      pause_from = k + p_after;
      pause_to   = k + p_after + p_len;
      push_run(k, lim, mode, nper, k + p_after, p_len);
    end else begin
      pause_from = 0;
      pause_to   = 0;
      push_run(k, lim, mode, nper, 32'h7fff_ffff, 0);
    end
  endtask

  task automatic test_reset();
    int k;
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.pause_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.limit_i = '0;
    #1;
    n_chk++;
    if (bus.count_o !== '0 || bus.tick_o !== 1'b0 || bus.done_o !== 1'b0 ||
        bus.busy_o !== 1'b0 || bus.state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_initial: count=%0d tick=%b done=%b busy=%b state=%0d, required all 0",
               bus.count_o, bus.tick_o, bus.done_o, bus.busy_o, bus.state_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_watch(3);
    check_status("idle_after_reset", 2'd0, '0, 1'b0);
    // Mid-run asynchronous reset between edges.
    do_start(5, 1'b0, 1, 0, 0, k);
    run_watch(23);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (bus.count_o !== '0 || bus.tick_o !== 1'b0 || bus.done_o !== 1'b0 ||
        bus.busy_o !== 1'b0 || bus.state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: count=%0d tick=%b done=%b busy=%b state=%0d, required all 0",
               bus.count_o, bus.tick_o, bus.done_o, bus.busy_o, bus.state_o);
    end
    #1 rst = 1'b1;
    sb.delete();
    run_watch(15);
    check_status("idle_after_midrun_reset", 2'd0, '0, 1'b0);
  endtask

  task automatic test_one_shot();
    int k;
    do_start(3, 1'b0, 1, 0, 0, k);
    run_watch(45);
    check_drained("one_shot");
    check_status("one_shot_done", 2'd3, 6'd3, 1'b0);
  endtask

  task automatic test_periodic();
    int k;
    do_start(63, 1'b1, 3, 0, 0, k);
    run_watch(3 * 64 * DIV + 5);
    check_drained("periodic");
    check_status("periodic_running", 2'd1, 6'd0, 1'b1);
    bus.stop_i = 1'b1;
    run_watch(1);
    bus.stop_i = 1'b0;
    check_status("periodic_stopped", 2'd0, '0, 1'b0);
  endtask

  task automatic test_pause();
    int k;
    do_start(3, 1'b0, 1, 15, 25, k);
    run_watch(70);
    pause_from = 0;
    pause_to   = 0;
    check_drained("pause");
    check_status("pause_done", 2'd3, 6'd3, 1'b0);
  endtask

  task automatic test_conflicts();
    int k;
    do_start(2, 1'b0, 1, 0, 0, k);
    run_watch(4);
    bus.limit_i = 6'd1;
    bus.mode_i  = 1'b1;
    bus.start_i = 1'b1;
    run_watch(1);
    bus.start_i = 1'b0;
    run_watch(30);
    check_drained("start_ignored");
    check_status("start_ignored_done", 2'd3, 6'd2, 1'b0);
    do_start(3, 1'b0, 1, 0, 0, k);
    run_watch(16);
    bus.stop_i  = 1'b1;
    bus.start_i = 1'b1;
    run_watch(1);
    bus.stop_i  = 1'b0;
    bus.start_i = 1'b0;
    check_status("stop_beats_start", 2'd0, '0, 1'b0);
    n_chk++;
    if (sb.size() != 3) begin
      n_fail++;
      $display("FAIL stop_queue: %0d events left, required 3", sb.size());
    end
    sb.delete();
    run_watch(60);
    check_status("stop_stays_idle", 2'd0, '0, 1'b0);
  endtask

  task automatic test_limit_zero();
    int k;
    do_start(0, 1'b0, 1, 0, 0, k);
    run_watch(15);
    check_drained("limit_zero");
    check_status("limit_zero_done", 2'd3, '0, 1'b0);
    do_start(2, 1'b0, 1, 0, 0, k);
    run_watch(35);
    check_drained("restart_from_done");
    check_status("restart_done", 2'd3, 6'd2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_pause();
    test_conflicts();
    test_limit_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
